// File: rtl/light_centroid_pkg.sv
// light_centroid_pkg: shared widths, FSM encodings and frame-end helpers for light_centroid.
// The optional LIGHT_CENTROID_HYST_EN macro is consumed by light_centroid.sv, not here.
package light_centroid_pkg;

   localparam int SUM_W = 32;
   localparam int CNT_W = 20;
   localparam int DIV_W = 32;
   localparam int H_W   = 11;
   localparam int V_W   = 10;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE   = 2'd0;
   localparam state_t ST_DIVIDE = 2'd1;
   localparam state_t ST_EMIT   = 2'd2;

   // Last active column/line: the frame-end beat sits at (last_col, last_row).
   function automatic logic [H_W-1:0] last_col(input int h_active);
      return H_W'(h_active - 1);
   endfunction

   function automatic logic [V_W-1:0] last_row(input int v_active);
      return V_W'(v_active - 1);
   endfunction

endpackage

// File: rtl/divider.sv
// divider: 32-bit unsigned restoring divider, one quotient bit per clock.
// quotient_out/data_valid_out appear 33 cycles after the cycle data_valid_in is high.
module divider (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        data_valid_in,
   input  logic [31:0] dividend_in,
   input  logic [31:0] divisor_in,
   output logic [31:0] quotient_out,
   output logic        data_valid_out
);

   logic [31:0] quo;
   logic [31:0] rem;
   logic [31:0] dvs;
   logic [5:0]  steps;
   logic [32:0] trial;
   logic [32:0] diff;
   logic        ge;

   // A clear borrow bit means the shifted remainder covers the divisor.
   always_comb begin
      trial = {rem, quo[31]};
      diff  = trial - {1'b0, dvs};
      ge    = ~diff[32];
   end

   always_ff @(posedge clk_in) begin
      // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
      if (rst_in) begin
         quo            <= '0;
         rem            <= '0;
         dvs            <= '0;
         steps          <= '0;
         quotient_out   <= '0;
         data_valid_out <= 1'b0;
      end else begin
         data_valid_out <= 1'b0;
         if (steps != 6'd0) begin
            quo   <= {quo[30:0], ge};
            rem   <= ge ? diff[31:0] : trial[31:0];
            steps <= steps - 6'd1;
            if (steps == 6'd1) begin
               quotient_out   <= {quo[30:0], ge};
               data_valid_out <= 1'b1;
            end
         end else if (data_valid_in) begin
            quo   <= dividend_in;
            rem   <= '0;
            dvs   <= divisor_in;
            steps <= 6'd32;
         end
      end
   end

endmodule

// File: rtl/light_centroid.sv
// light_centroid: per-frame bright-pixel centroid with a light-present flag and drop detection.
// Define LIGHT_CENTROID_HYST_EN for two-frame hysteresis on light_out.
module light_centroid
   import light_centroid_pkg::*;
#(
   parameter int H_ACTIVE   = 1280,
   parameter int V_ACTIVE   = 720,
   parameter int MIN_PIXELS = 16
) (
   input  logic           clk_in,
   input  logic           rst_in,
   input  logic           pixel_valid_in,
   input  logic [H_W-1:0] hcount_in,
   input  logic [V_W-1:0] vcount_in,
   input  logic [7:0]     luma_in,
   input  logic [7:0]     thresh_in,
   output logic [H_W-1:0] x_out,
   output logic [V_W-1:0] y_out,
   output logic           light_out,
   output logic           valid_out,
   output logic           overrun_out
);

   localparam logic [H_W-1:0]   H_LAST  = last_col(H_ACTIVE);
   localparam logic [V_W-1:0]   V_LAST  = last_row(V_ACTIVE);
   localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(MIN_PIXELS);

   logic [SUM_W-1:0] sum_x;
   logic [SUM_W-1:0] sum_y;
   logic [CNT_W-1:0] count;
   logic [SUM_W-1:0] div_sx;
   logic [SUM_W-1:0] div_sy;
   logic [CNT_W-1:0] div_cnt;
   logic             pending;

   state_t           state;
   logic             div_start;
   logic             done_x;
   logic             done_y;
   logic             light_n;
   logic [H_W-1:0]   x_q;
   logic [V_W-1:0]   y_q;

   logic [DIV_W-1:0] quot_x;
   logic [DIV_W-1:0] quot_y;
   logic             quot_x_valid;
   logic             quot_y_valid;

   logic             bright;
   logic             frame_end;
   logic             busy;
   logic [SUM_W-1:0] add_x;
   logic [SUM_W-1:0] add_y;
   logic             bright_frame;
   logic             both_done;
   logic             enter_emit;
   logic             light_next;

`ifdef LIGHT_CENTROID_HYST_EN
   logic [1:0]       hist;
`endif

   // NOTE: every signal below is assigned on every pass, so no latch can be inferred.
   always_comb begin
      bright       = pixel_valid_in && (luma_in >= thresh_in)
                     && (hcount_in <= H_LAST) && (vcount_in <= V_LAST);
      frame_end    = pixel_valid_in && (hcount_in == H_LAST) && (vcount_in == V_LAST);
      add_x        = bright ? SUM_W'(hcount_in) : '0;
      add_y        = bright ? SUM_W'(vcount_in) : '0;
      busy         = pending || (state != ST_IDLE);
      bright_frame = (div_cnt >= MIN_CNT);
      both_done    = (done_x || quot_x_valid) && (done_y || quot_y_valid);
      enter_emit   = ((state == ST_IDLE) && pending && !bright_frame)
                     || ((state == ST_DIVIDE) && both_done);
      light_next   = (state == ST_DIVIDE);
   end

   // Accumulation and frame snapshot; a frame ending while a result is in flight is dropped.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         sum_x       <= '0;
         sum_y       <= '0;
         count       <= '0;
         div_sx      <= '0;
         div_sy      <= '0;
         div_cnt     <= '0;
         pending     <= 1'b0;
         overrun_out <= 1'b0;
      end else begin
         overrun_out <= frame_end && busy;
         if (frame_end) begin
            sum_x <= '0;
            sum_y <= '0;
            count <= '0;
            if (!busy) begin
               div_sx  <= sum_x + add_x;
               div_sy  <= sum_y + add_y;
               div_cnt <= count + CNT_W'(bright);
               pending <= 1'b1;
            end
         end else begin
            sum_x <= sum_x + add_x;
            sum_y <= sum_y + add_y;
            count <= count + CNT_W'(bright);
         end
         if ((state == ST_IDLE) && pending)
            pending <= 1'b0;
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state     <= ST_IDLE;
         div_start <= 1'b0;
         done_x    <= 1'b0;
         done_y    <= 1'b0;
         light_n   <= 1'b0;
         x_q       <= '0;
         y_q       <= '0;
         x_out     <= '0;
         y_out     <= '0;
         light_out <= 1'b0;
         valid_out <= 1'b0;
`ifdef LIGHT_CENTROID_HYST_EN
         hist      <= 2'b00;
`endif
      end else begin
         div_start <= 1'b0;
         valid_out <= 1'b0;
         if (enter_emit) begin
            light_n <= light_next;
`ifdef LIGHT_CENTROID_HYST_EN
            hist    <= {hist[0], light_next};
`endif
         end
         case (state)
            ST_IDLE: begin
               if (pending) begin
                  if (bright_frame) begin
                     div_start <= 1'b1;
                     done_x    <= 1'b0;
                     done_y    <= 1'b0;
                     state     <= ST_DIVIDE;
                  end else begin
                     state     <= ST_EMIT;
                  end
               end
            end
            ST_DIVIDE: begin
               // The two quotients may land on different cycles; each is held until both exist.
               if (quot_x_valid) begin
                  x_q    <= quot_x[H_W-1:0];
                  done_x <= 1'b1;
               end
               if (quot_y_valid) begin
                  y_q    <= quot_y[V_W-1:0];
                  done_y <= 1'b1;
               end
               if (both_done)
                  state <= ST_EMIT;
            end
            ST_EMIT: begin
               valid_out <= 1'b1;
`ifdef LIGHT_CENTROID_HYST_EN
               if (hist == 2'b11)
                  light_out <= 1'b1;
               else if (hist == 2'b00)
                  light_out <= 1'b0;
`else
               light_out <= light_n;
`endif
               if (light_n) begin
                  x_out <= x_q;
                  y_out <= y_q;
               end
               state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   divider u_div_x (
      .clk_in         (clk_in),
      .rst_in         (rst_in),
      .data_valid_in  (div_start),
      .dividend_in    (div_sx),
      .divisor_in     (DIV_W'(div_cnt)),
      .quotient_out   (quot_x),
      .data_valid_out (quot_x_valid)
   );

   divider u_div_y (
      .clk_in         (clk_in),
      .rst_in         (rst_in),
      .data_valid_in  (div_start),
      .dividend_in    (div_sy),
      .divisor_in     (DIV_W'(div_cnt)),
      .quotient_out   (quot_y),
      .data_valid_out (quot_y_valid)
   );

   // Centroids never exceed the active area, so the quotient high bits are always zero.
   logic unused_quot;
   assign unused_quot = ^{quot_x[DIV_W-1:H_W], quot_y[DIV_W-1:V_W]};

endmodule

// File: tb/tb_light_centroid.sv
// tb_light_centroid: directed and random frames on an 8x4 raster, checked every cycle
// against a frame-level model (sums, counts, integer division, fixed result latencies).
`timescale 1ns/1ps
module tb_light_centroid;

   localparam int H          = 8;
   localparam int V          = 4;
   localparam int MINP       = 4;
   localparam int DIV_LAT    = 33;
   localparam int BRIGHT_LAT = DIV_LAT + 3;
   localparam int DIM_LAT    = 2;

   logic        clk_in         = 1'b0;
   logic        rst_in         = 1'b1;
   logic        pixel_valid_in = 1'b0;
   logic [10:0] hcount_in      = '0;
   logic [9:0]  vcount_in      = '0;
   logic [7:0]  luma_in        = '0;
   logic [7:0]  thresh_in      = '0;
   logic [10:0] x_out;
   logic [9:0]  y_out;
   logic        light_out;
   logic        valid_out;
   logic        overrun_out;

   light_centroid #(.H_ACTIVE(H), .V_ACTIVE(V), .MIN_PIXELS(MINP)) dut (
      .clk_in         (clk_in),
      .rst_in         (rst_in),
      .pixel_valid_in (pixel_valid_in),
      .hcount_in      (hcount_in),
      .vcount_in      (vcount_in),
      .luma_in        (luma_in),
      .thresh_in      (thresh_in),
      .x_out          (x_out),
      .y_out          (y_out),
      .light_out      (light_out),
      .valid_out      (valid_out),
      .overrun_out    (overrun_out)
   );

   always #5 clk_in = ~clk_in;

   int cyc = 0;
   always @(posedge clk_in) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Frame-level model: expected result pulses and overrun pulses, keyed by due cycle.
   typedef struct {
      int due;
      bit light;
      int x;
      int y;
   } result_t;

   result_t res_q[$];
   int      ovr_q[$];
   int      m_sx, m_sy, m_cnt;
   int      busy_until = -1;
   int      px, py;
   bit      pl, prev_n;
   int      cur_x, cur_y;
   bit      cur_light;
   int      fe_cyc;
   bit      mon_en = 1'b0;
   int      ovr_seen = 0;
   int      valid_seen = 0;
   logic [7:0] img [H*V];

`ifdef LIGHT_CENTROID_HYST_EN
   bit hyst_exp [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
`endif

   task automatic frame_done(input int e0);
      bit n;
      if (e0 <= busy_until) begin
         ovr_q.push_back(e0);
      end else begin
         n = (m_cnt >= MINP);
         if (n) begin
            px = m_sx / m_cnt;
            py = m_sy / m_cnt;
         end
`ifdef LIGHT_CENTROID_HYST_EN
         if (n == prev_n) pl = n;
         prev_n = n;
`else
         pl = n;
`endif
         busy_until = e0 + (n ? BRIGHT_LAT : DIM_LAT);
         res_q.push_back('{busy_until, pl, px, py});
      end
      fe_cyc = e0;
      m_sx   = 0;
      m_sy   = 0;
      m_cnt  = 0;
   endtask

   task automatic beat(input bit pv, input int h, input int v, input int l, input int th);
      @(posedge clk_in);
      #1;
      pixel_valid_in = pv;
      hcount_in      = 11'(h);
      vcount_in      = 10'(v);
      luma_in        = 8'(l);
      thresh_in      = 8'(th);
      if (pv) begin
         if (l >= th && h < H && v < V) begin
            m_sx += h;
            m_sy += v;
            m_cnt++;
         end
         if (h == H - 1 && v == V - 1) frame_done(cyc + 1);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) beat(1'b0, H - 1, V - 1, 255, 128);
   endtask

   task automatic send_frame(input int th, input int gap_pct, input int oob_pct);
      for (int v = 0; v < V; v++) begin
         for (int h = 0; h < H; h++) begin
            if (int'($urandom_range(99)) < gap_pct) beat(1'b0, H - 1, V - 1, 255, th);
            if (int'($urandom_range(99)) < oob_pct) begin
               if ($urandom_range(1) == 1)
                  beat(1'b1, H + int'($urandom_range(H - 1)), int'($urandom_range(V - 1)), 255, th);
               else
                  beat(1'b1, int'($urandom_range(H - 1)), V + int'($urandom_range(V - 1)), 255, th);
            end
            beat(1'b1, h, v, int'(img[v*H+h]), th);
         end
      end
      beat(1'b0, 0, 0, 0, th);
   endtask

   task automatic clear_img();
      foreach (img[i]) img[i] = 8'd0;
   endtask

   task automatic lit(input int h, input int v);
      img[v*H+h] = 8'd200;
   endtask

   task automatic img_quad();
      clear_img();
      lit(2, 1); lit(4, 1); lit(2, 3); lit(4, 3);
   endtask

   task automatic wait_valid(input string name, output int at);
      at = -1;
      for (int i = 0; i < 200 && at < 0; i++) begin
         @(negedge clk_in);
         if (valid_out === 1'b1) at = cyc;
      end
      if (at < 0) check({name, "_timeout"}, 32'(valid_out), 32'd1);
   endtask

   task automatic do_reset(input int n);
      @(posedge clk_in);
      #1;
      rst_in         = 1'b1;
      pixel_valid_in = 1'b0;
      repeat (n) @(posedge clk_in);
      #1;
      rst_in = 1'b0;
      res_q.delete();
      ovr_q.delete();
      m_sx = 0; m_sy = 0; m_cnt = 0;
      busy_until = -1;
      prev_n = 1'b0; pl = 1'b0; px = 0; py = 0;
      cur_x = 0; cur_y = 0; cur_light = 1'b0;
   endtask

   // Every-cycle comparison of all outputs against the model.
   always @(negedge clk_in) begin : monitor
      bit      ev;
      bit      eo;
      result_t r;
      if (mon_en && !rst_in) begin
         ev = (res_q.size() > 0) && (res_q[0].due == cyc);
         check("valid_out", 32'(valid_out), 32'(ev));
         if (ev) begin
            r         = res_q.pop_front();
            cur_light = r.light;
            cur_x     = r.x;
            cur_y     = r.y;
         end
         check("light_out", 32'(light_out), 32'(cur_light));
         check("x_out", 32'(x_out), cur_x);
         check("y_out", 32'(y_out), cur_y);
         eo = (ovr_q.size() > 0) && (ovr_q[0] == cyc);
         check("overrun_out", 32'(overrun_out), 32'(eo));
         if (eo) ovr_q.delete(0);
         if (overrun_out === 1'b1) ovr_seen++;
         if (valid_out === 1'b1) valid_seen++;
      end
   end

   initial begin
      int at;
      int base;

      do_reset(3);
      check("reset_x", 32'(x_out), 32'd0);
      check("reset_y", 32'(y_out), 32'd0);
      check("reset_light", 32'(light_out), 32'd0);
      check("reset_valid", 32'(valid_out), 32'd0);
      check("reset_overrun", 32'(overrun_out), 32'd0);
      mon_en = 1'b1;

`ifdef LIGHT_CENTROID_HYST_EN
      for (int f = 0; f < 5; f++) begin
         if (f < 2) img_quad(); else clear_img();
         send_frame(128, 0, 0);
         wait_valid("hyst", at);
         check($sformatf("hyst_light_%0d", f), 32'(light_out), 32'(hyst_exp[f]));
      end
`endif

      // Symmetric quad: centroid (3,2).
      img_quad();
      send_frame(128, 0, 0);
      wait_valid("quad", at);
      check("quad_latency", at - fe_cyc, BRIGHT_LAT);
      check("quad_x", 32'(x_out), 32'd3);
      check("quad_y", 32'(y_out), 32'd2);
`ifndef LIGHT_CENTROID_HYST_EN
      check("quad_light", 32'(light_out), 32'd1);
`endif

      // 13/4 truncates to 3, 1/4 truncates to 0.
      clear_img();
      lit(1, 0); lit(2, 0); lit(4, 0); lit(6, 1);
      send_frame(128, 0, 0);
      wait_valid("trunc", at);
      check("trunc_x", 32'(x_out), 32'd3);
      check("trunc_y", 32'(y_out), 32'd0);

      // Three bright pixels is below MIN_PIXELS: dim, coordinates hold.
      clear_img();
      lit(0, 0); lit(5, 2); lit(7, 1);
      send_frame(128, 0, 0);
      wait_valid("dim", at);
      check("dim_latency", at - fe_cyc, DIM_LAT);
      check("dim_light", 32'(light_out), 32'd0);
      check("dim_x_hold", 32'(x_out), 32'd3);
      check("dim_y_hold", 32'(y_out), 32'd0);

      // Frame-end beat is itself bright; next frame must start from zero.
      clear_img();
      lit(7, 0); lit(7, 1); lit(7, 2); lit(7, 3);
      send_frame(128, 0, 0);
      wait_valid("edge", at);
      check("edge_x", 32'(x_out), 32'd7);
      check("edge_y", 32'(y_out), 32'd1);
      clear_img();
      lit(0, 0); lit(1, 0); lit(2, 0);
      send_frame(128, 0, 0);
      wait_valid("edge_next", at);
      check("edge_next_light", 32'(light_out), 32'd0);
      check("edge_next_x_hold", 32'(x_out), 32'd7);

      // Frame end while dividing: one overrun pulse, prior result still emitted.
      base = ovr_seen;
      img_quad();
      send_frame(128, 0, 0);
      idle(3);
      beat(1'b1, H - 1, V - 1, 200, 128);
      idle(1);
      wait_valid("ovr", at);
      check("ovr_x", 32'(x_out), 32'd3);
      check("ovr_y", 32'(y_out), 32'd2);
      check("ovr_pulses", ovr_seen - base, 32'd1);
      clear_img();
      lit(1, 0); lit(2, 0); lit(4, 0); lit(6, 1);
      send_frame(128, 0, 0);
      wait_valid("ovr_next", at);
      check("ovr_next_x", 32'(x_out), 32'd3);
      check("ovr_next_y", 32'(y_out), 32'd0);

      // Reset while dividing: outputs clear and the in-flight result never appears.
      img_quad();
      send_frame(128, 0, 0);
      idle(10);
      do_reset(2);
      check("rst_mid_x", 32'(x_out), 32'd0);
      check("rst_mid_y", 32'(y_out), 32'd0);
      check("rst_mid_light", 32'(light_out), 32'd0);
      base = valid_seen;
      idle(60);
      check("rst_mid_no_valid", valid_seen - base, 32'd0);

      // Random frames with gaps, out-of-area beats and natural overruns.
      for (int f = 0; f < 40; f++) begin
         int th;
         th = int'($urandom_range(255, 60));
         foreach (img[i]) img[i] = 8'($urandom_range(255));
         send_frame(th, 15, 8);
         repeat ($urandom_range(45)) begin
            beat(1'b0, int'($urandom_range(15)), int'($urandom_range(7)), int'($urandom_range(255)), th);
         end
      end

      idle(60);
      check("drain_results", res_q.size(), 32'd0);
      check("drain_overruns", ovr_q.size(), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
